dmem_responder: RTL

- Responder end of the CPU data-memory interface.
- The core's load/store path (LDUR/STUR) issues requests on a valid/ready handshake.
- This block accepts one request at a time, inserts a programmable number of wait states, then reads or writes a 64-bit little-endian doubleword and returns a response.
- It replaces the single-cycle data memory once the datapath becomes multi-cycle.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_byte_array.sv | 36 +++
 rtl/dmem_responder.sv | 111 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Doublewords are handled as eight little-endian byte lanes: lane 0 is data[7:0].
package dmem_pkg;

  localparam int unsigned DW_BYTES = 8;
  localparam int unsigned DW_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [DW_BYTES-1:0][7:0] dw_bytes_t;

  function automatic logic [DW_W-1:0] assemble_dw(input dw_bytes_t b);
    return DW_W'(b);
  endfunction

  function automatic dw_bytes_t split_dw(input logic [DW_W-1:0] d);
    return dw_bytes_t'(d);
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage with an 8-lane combinational read port and an 8-lane
// synchronous write port; lane k addresses (idx + k) mod DEPTH_BYTES.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH_BYTES = 256,
  localparam int unsigned AW          = $clog2(DEPTH_BYTES)
) (
  input  logic            clk,
  input  logic [AW-1:0]   rd_idx,
  output dw_bytes_t       rd_bytes,
  input  logic            we,
  input  logic [AW-1:0]   wr_idx,
  input  dw_bytes_t       wr_bytes
);

  logic [7:0]    mem     [DEPTH_BYTES];
  logic [AW-1:0] rd_lane [DW_BYTES];
  logic [AW-1:0] wr_lane [DW_BYTES];

  // AW-bit addition gives the wrap around the top of memory for free.
  for (genvar k = 0; k < DW_BYTES; k++) begin : g_lane
    assign rd_lane[k]  = rd_idx + AW'(k);
    assign wr_lane[k]  = wr_idx + AW'(k);
    assign rd_bytes[k] = mem[rd_lane[k]];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned k = 0; k < DW_BYTES; k++) begin
        mem[wr_lane[k]] <= wr_bytes[k];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory interface: one request at a time,
// LATENCY wait states, 64-bit little-endian access. Optional DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DATA_W      = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              cap_write;
  logic              cap_err;
  logic [AW-1:0]     cap_idx;
  logic [DATA_W-1:0] cap_wdata;
  logic              misaligned;
  logic              mem_we;
  dw_bytes_t         rd_bytes;
  logic              unused_addr;

  assign unused_addr = ^req_addr[63:AW];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = |req_addr[2:0];
`else
  assign misaligned = 1'b0;
`endif

  // Store commits on the final BUSY edge; an async reset before then drops it.
  assign mem_we = (state == BUSY) && (cnt == CW'(1)) && cap_write && !cap_err;

  dmem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .clk      (clk),
    .rd_idx   (cap_idx),
    .rd_bytes (rd_bytes),
    .we       (mem_we),
    .wr_idx   (cap_idx),
    .wr_bytes (split_dw(cap_wdata))
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_err   <= misaligned;
            cap_idx   <= req_addr[AW-1:0];
            cap_wdata <= req_wdata;
            cnt       <= CW'(LATENCY);
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rsp_rdata <= (cap_write || cap_err) ? '0 : assemble_dw(rd_bytes);
            rsp_err   <= cap_err;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
